reg_pipe_chain: RTL
===================

Name: reg_pipe_chain

Overview:
Parametrised elastic register pipeline. It is the generalised successor of the fixed two-register chain (input register feeding a second register). It carries CHANNELS lanes of WIDTH bits through DEPTH stages under a valid/ready handshake, with bubble collapsing, synchronous flush and an occupancy count. It sits between a producer and a consumer in the same clock domain wherever a configurable registered delay with backpressure is needed.

Parameters:
WIDTH, 1, bits per channel lane
DEPTH, 2, number of register stages (>=1)
CHANNELS, 1, parallel lanes sharing one handshake
RESET_VAL, 0, value loaded into every data lane on reset and flush

Ports:
CLK  input  1  clock; all state updates on its rising edge
RST  input  1  reset; synchronous, active-low
in_valid  input  1  producer has data on in_data
in_ready  output  1  pipeline accepts in_data this cycle
in_data  input  CHANNELS*WIDTH  lane c at bits [c*WIDTH +: WIDTH]
out_valid  output  1  last stage holds valid data
out_ready  input  1  consumer takes out_data this cycle
out_data  output  CHANNELS*WIDTH  last-stage data
flush  input  1  discard all held data
occupancy  output  $clog2(DEPTH+1)  number of valid stages

Behaviour:
- Reset (RST==0 at a CLK edge): all stage valids = 0, all data = RESET_VAL, occupancy = 0, out_valid = 0. in_ready is combinational and therefore reads 1 during reset. Inputs are ignored while RST==0. Reset mid-transfer drops everything silently.
- Stage k (0..DEPTH-1; stage 0 takes input, stage DEPTH-1 drives outputs) holds valid[k] and data[k].
- Advance rule, evaluated from the tail: adv[DEPTH-1] = !valid[DEPTH-1] || out_ready. For k<DEPTH-1: adv[k] = !valid[k] || adv[k+1]. All combinational; no registered ready path.
- in_ready = adv[0]. An input transfer occurs when in_valid && in_ready. An output transfer occurs when out_valid && out_ready.
- When adv[k] is true, stage k loads from stage k-1 (or from input for k=0): valid[k] <= valid[k-1] (in_valid for k=0), data[k] <= data[k-1]. Data is loaded only when the incoming valid is 1; otherwise data holds its old value.
- When adv[k] is false, stage k holds its state.
- Bubble collapsing: a stalled output still lets upstream stages fill empty slots. Full capacity is DEPTH entries. in_ready = 0 only when all DEPTH stages are valid and out_ready == 0.
- Latency: DEPTH cycles from input transfer to out_valid, with an empty pipe and out_ready held high. Throughput is 1 per cycle.
- out_data = data[DEPTH-1] whenever out_valid == 1. Its value is don't-care when out_valid == 0, but it is stable while out_valid && !out_ready.
- Flush (RST==1, flush==1): next cycle all valid = 0, data = RESET_VAL, occupancy = 0.
  - Flush has priority over any input or output transfer in the same cycle.
  - The producer sees in_ready per the normal rule, but the beat is discarded.
  - An output transfer in the flush cycle still completes for the consumer. out_valid/out_data are unchanged until the edge.
- Occupancy: registered.
  - occ_next = occ + (input transfer) - (output transfer); 0 on flush or reset.
  - Never exceeds DEPTH and never underflows. A simultaneous in and out transfer leaves it unchanged.
- Lanes are independent bit-slices. No arithmetic is performed on data.

Decomposition:
- Shared package reg_pipe_pkg: occupancy-width function clog2_plus1(DEPTH) and default parameter constants. No typedefs are needed beyond a flat vector.
- One natural sub-module: reg_pipe_stage (valid + CHANNELS*WIDTH data register, load on adv, clear on flush/reset). Instantiate it DEPTH times in a generate loop.
- The top level holds the adv chain and the occupancy counter.

Test Plan:
1. Config WIDTH=8, DEPTH=2, CHANNELS=1. Reset, then stream 0x01..0x05 with out_ready=1 -> out_data 0x01..0x05 appear 2 cycles after each input, occupancy steady at 2, in_ready stays 1.
2. DEPTH=3. Hold out_ready=0 and offer 0xA1,0xA2,0xA3,0xA4 -> first three accepted, in_ready drops after the third, occupancy=3. Then raise out_ready -> 0xA1,0xA2,0xA3,0xA4 delivered in order with no loss or duplication.
3. Bubble collapse, DEPTH=4. Inputs on cycles 0 and 3, out_ready=0 -> both entries pack into stages 3 and 2, occupancy=2, in_ready=1.
4. Flush with 3 valid entries and a simultaneous input beat 0x55 -> next cycle out_valid=0, occupancy=0, and 0x55 never appears at the output.
5. Reset mid-stream: RST=0 for one edge with occupancy=2 -> out_valid=0, occupancy=0. After reset, a new beat 0x7E emerges after DEPTH cycles.
6. CHANNELS=4, WIDTH=4. Input 0xDCBA -> output 0xDCBA with each lane unchanged. While stalled, out_data is held stable for 5 cycles.

Source files
------------

// File: rtl/reg_pipe_pkg.sv
// Shared constants and helpers for the elastic register pipeline.
package reg_pipe_pkg;

  localparam int DEF_WIDTH    = 32'd1;
  localparam int DEF_DEPTH    = 32'd2;
  localparam int DEF_CHANNELS = 32'd1;

  // Bits needed to count 0..depth inclusive.
  function automatic int clog2_plus1(input int depth);
    return $clog2(depth + 32'sd1);
  endfunction

endpackage

// File: rtl/reg_pipe_stage.sv
// One pipeline slot: a valid flag plus the full multi-lane data word.
module reg_pipe_stage #(
  parameter int              DW         = 32'd1,
  parameter logic [DW-1:0]   RESET_WORD = '0
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          flush,
  input  logic          adv,
  input  logic          src_valid,
  input  logic [DW-1:0] src_data,
  output logic          valid,
  output logic [DW-1:0] data
);

  logic          valid_r;
  logic [DW-1:0] data_r;

  // Slot register: cleared by reset or flush, otherwise takes the upstream beat when allowed to advance.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      valid_r <= 1'b0;
      data_r  <= RESET_WORD;
    end else if (flush) begin
      valid_r <= 1'b0;
      data_r  <= RESET_WORD;
    end else if (adv) begin
      valid_r <= src_valid;
      // Data only moves with a real beat, so an empty slot keeps its old contents.
      if (src_valid) begin
        data_r <= src_data;
      end
    end
  end

  assign valid = valid_r;
  assign data  = data_r;

endmodule

// File: rtl/reg_pipe_chain.sv
// Elastic register pipeline: DEPTH slots of CHANNELS*WIDTH bits under valid/ready,
// with bubble collapsing, synchronous flush and a registered occupancy count.
module reg_pipe_chain
  import reg_pipe_pkg::*;
#(
  parameter int                 WIDTH     = DEF_WIDTH,
  parameter int                 DEPTH     = DEF_DEPTH,
  parameter int                 CHANNELS  = DEF_CHANNELS,
  parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
  input  logic                              CLK,
  input  logic                              RST,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [CHANNELS*WIDTH-1:0]         in_data,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [CHANNELS*WIDTH-1:0]         out_data,
  input  logic                              flush,
  output logic [clog2_plus1(DEPTH)-1:0]     occupancy
);

  localparam int            DW         = CHANNELS * WIDTH;
  localparam int            OCC_W      = clog2_plus1(DEPTH);
  localparam logic [DW-1:0] RESET_WORD = {CHANNELS{RESET_VAL}};

  logic [DEPTH-1:0] valid_s;
  logic [DEPTH-1:0] adv_s;
  logic [DW-1:0]    data_s [DEPTH];
  logic             in_xfer_s;
  logic             out_xfer_s;
  logic [OCC_W-1:0] occ_r;

  // Advance chain from the tail: a slot may move if it is empty or everything ahead of it moves.
  always_comb begin
    logic slot_free_s;
    adv_s       = '0;
    slot_free_s = out_ready;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      slot_free_s = slot_free_s || !valid_s[k];
      adv_s[k]    = slot_free_s;
    end
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    logic          src_valid_s;
    logic [DW-1:0] src_data_s;

    if (k == 0) begin : g_head
      assign src_valid_s = in_valid;
      assign src_data_s  = in_data;
    end else begin : g_link
      assign src_valid_s = valid_s[k-1];
      assign src_data_s  = data_s[k-1];
    end

    reg_pipe_stage #(
      .DW         (DW),
      .RESET_WORD (RESET_WORD)
    ) u_stage (
      .CLK       (CLK),
      .RST       (RST),
      .flush     (flush),
      .adv       (adv_s[k]),
      .src_valid (src_valid_s),
      .src_data  (src_data_s),
      .valid     (valid_s[k]),
      .data      (data_s[k])
    );
  end

  assign in_ready   = adv_s[0];
  assign out_valid  = valid_s[DEPTH-1];
  assign out_data   = data_s[DEPTH-1];
  assign in_xfer_s  = in_valid && adv_s[0];
  assign out_xfer_s = valid_s[DEPTH-1] && out_ready;

  // Occupancy tracks accepted minus delivered beats; reset and flush empty it.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      occ_r <= {OCC_W{1'b0}};
    end else if (flush) begin
      occ_r <= {OCC_W{1'b0}};
    end else begin
      occ_r <= occ_r + OCC_W'(in_xfer_s) - OCC_W'(out_xfer_s);
    end
  end

  assign occupancy = occ_r;

endmodule
